// File: rtl/fixed_p_std_div_pipe.sv
// Unsigned fixed-point divider: (left << fract_width) / right, computed by
// restoring division one quotient bit per cycle, MSB first.
module fixed_p_std_div_pipe #(
    parameter int width       = 32,
    parameter int int_width   = 8,
    parameter int fract_width = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [width-1:0] left,
    input  logic [width-1:0] right,
    output logic [width-1:0] out_quotient,
    output logic [width-1:0] out_remainder,
    output logic             done
);

    localparam int ITER = width + fract_width;
    localparam int CW   = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    if (int_width + fract_width != width) begin : g_format_check
        $error("fixed_p_std_div_pipe: int_width + fract_width must equal width");
    end

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [ITER-1:0]     dvd_q, dvd_d;
    logic [width-1:0]    div_q, div_d;
    logic [width-1:0]    rem_q, rem_d;
    logic [width-1:0]    quo_q, quo_d;
    logic [width-1:0]    out_quotient_q, out_quotient_d;
    logic [width-1:0]    out_remainder_q, out_remainder_d;
    logic                done_q, done_d;

    logic [width:0]      trial_s;
    logic [width:0]      diff_s;
    logic [width-1:0]    rem_nxt_s;
    logic [width-1:0]    quo_nxt_s;

    // Next-state, datapath iteration and result loading.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        dvd_d           = dvd_q;
        div_d           = div_q;
        rem_d           = rem_q;
        quo_d           = quo_q;
        out_quotient_d  = out_quotient_q;
        out_remainder_d = out_remainder_q;
        done_d          = 1'b0;

        // Partial remainder stays below the divisor, so width+1 bits hold the shifted trial.
        trial_s = {rem_q, dvd_q[ITER-1]};
        diff_s  = trial_s - {1'b0, div_q};
        if (diff_s[width] == 1'b0) begin
            rem_nxt_s = diff_s[width-1:0];
            quo_nxt_s = {quo_q[width-2:0], 1'b1};
        end else begin
            rem_nxt_s = trial_s[width-1:0];
            quo_nxt_s = {quo_q[width-2:0], 1'b0};
        end

        case (state_q)
            IDLE: begin
                if (go) begin
                    if (right != {width{1'b0}}) begin
                        dvd_d   = {left, {fract_width{1'b0}}};
                        div_d   = right;
                        rem_d   = {width{1'b0}};
                        quo_d   = {width{1'b0}};
                        cnt_d   = {CW{1'b0}};
                        state_d = RUN;
                    end else begin
                        out_quotient_d  = {width{1'b1}};
                        out_remainder_d = left;
                        done_d          = 1'b1;
                        state_d         = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                dvd_d = {dvd_q[ITER-2:0], 1'b0};
                rem_d = rem_nxt_s;
                quo_d = quo_nxt_s;
                if (cnt_q == CW'(ITER - 1)) begin
                    out_quotient_d  = quo_nxt_s;
                    out_remainder_d = rem_nxt_s;
                    done_d          = 1'b1;
                    state_d         = DONE;
                end else begin
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= IDLE;
            cnt_q           <= {CW{1'b0}};
            dvd_q           <= {ITER{1'b0}};
            div_q           <= {width{1'b0}};
            rem_q           <= {width{1'b0}};
            quo_q           <= {width{1'b0}};
            out_quotient_q  <= {width{1'b0}};
            out_remainder_q <= {width{1'b0}};
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            dvd_q           <= dvd_d;
            div_q           <= div_d;
            rem_q           <= rem_d;
            quo_q           <= quo_d;
            out_quotient_q  <= out_quotient_d;
            out_remainder_q <= out_remainder_d;
            done_q          <= done_d;
        end
    end

    assign out_quotient  = out_quotient_q;
    assign out_remainder = out_remainder_q;
    assign done          = done_q;

endmodule
